// File: rtl/stage_word_packer_if.sv
// Handshake bundle for stage_word_packer: narrow input beats in, packed wide words out.
// valid/ready: a transfer happens on a rising clk edge where valid && ready; the source holds its payload stable until then.
interface stage_word_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_W-1:0]         in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [IN_W*RATIO-1:0]   out_data;
  logic [RATIO-1:0]        out_keep;
  logic                    out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/stage_word_packer.sv
// Packs up to RATIO narrow input beats (fewer when a beat carries in_last) into one wide output word.
// One output register; it reloads in the same cycle it is drained, so full-rate streaming has no bubble.
module stage_word_packer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  stage_word_packer_if.slave    bus,
  output logic [CNT_W-1:0]      word_count,
  output logic                  state_dbg
);

  localparam int W      = IN_W * RATIO;
  localparam int LIDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [LIDX_W-1:0]   lane_idx, lane_nxt;
  logic [W-1:0]        acc, acc_nxt;
  logic [W-1:0]        data_q, data_nxt;
  logic [RATIO-1:0]    keep_q, keep_nxt;
  logic                last_q, last_nxt;
  logic                valid_q, valid_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;

  logic                accept;
  logic                last_lane;
  logic                complete;
  logic                drain;
  logic [W-1:0]        beat_word;
  logic [W-1:0]        merged;
  logic [RATIO-1:0]    keep_mask;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = valid_q && bus.out_ready;
  assign last_lane    = (lane_idx == LIDX_W'(RATIO - 1));
  assign complete     = accept && (bus.in_last || last_lane);

  // The incoming beat is positioned in its lane and OR-ed onto the partial word.
  assign beat_word = W'(bus.in_data) << (int'(lane_idx) * IN_W);
  assign merged    = acc | beat_word;
  assign keep_mask = {RATIO{1'b1}} >> (RATIO - 1 - int'(lane_idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      lane_idx <= '0;
      acc      <= '0;
      data_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      lane_idx <= lane_nxt;
      acc      <= acc_nxt;
      data_q   <= data_nxt;
      keep_q   <= keep_nxt;
      last_q   <= last_nxt;
      valid_q  <= valid_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lane_nxt  = lane_idx;
    acc_nxt   = acc;
    data_nxt  = data_q;
    keep_nxt  = keep_q;
    last_nxt  = last_q;
    valid_nxt = valid_q;
    cnt_nxt   = cnt_q;

    case (state)
      EMPTY: begin
        if (accept) begin
          if (complete) begin
            state_nxt = EMPTY;
            lane_nxt  = '0;
            acc_nxt   = '0;
          end else begin
            state_nxt = FILL;
            lane_nxt  = LIDX_W'(1);
            acc_nxt   = merged;
          end
        end
      end
      FILL: begin
        if (accept) begin
          if (complete) begin
            state_nxt = EMPTY;
            lane_nxt  = '0;
            acc_nxt   = '0;
          end else begin
            lane_nxt  = lane_idx + LIDX_W'(1);
            acc_nxt   = merged;
          end
        end
      end
      default: begin
        state_nxt = EMPTY;
        lane_nxt  = '0;
        acc_nxt   = '0;
      end
    endcase

    // A completing beat always wins over a drain, so a reload keeps out_valid high.
    if (complete) begin
      valid_nxt = 1'b1;
      data_nxt  = merged;
      keep_nxt  = keep_mask;
      last_nxt  = bus.in_last;
    end else if (drain) begin
      valid_nxt = 1'b0;
    end

    if (drain) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_keep  = keep_q;
  assign bus.out_last  = last_q;
  assign word_count    = cnt_q;
  assign state_dbg     = state;

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (valid_q && !bus.out_ready) |=> ($stable(data_q) && $stable(keep_q) && $stable(last_q)));

endmodule
